// File: rtl/mem_port_arbiter_pkg.sv
// Types shared by the memory-port arbiter and its bench: FSM states, the
// registered request bundle and the canonical NOP encoding.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } mem_req_t;

    localparam logic [31:0] NOP_INST = 32'h00000013;

endpackage

// File: rtl/arb_starve_counter.sv
// Counts consecutive D-side grants that bypassed a waiting I-side request;
// limit_hit hands the next grant to the I-side.
module arb_starve_counter #(
    parameter int MAX = 4,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    input  logic [CW-1:0] sat,
    output logic          limit_hit
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q < sat))
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign limit_hit = (cnt_q >= sat);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between fetch (I) and memory stage (D);
// one outstanding request, registered at grant, response routed to owner.
module mem_port_arbiter
    import rv32i_types::*;
#(
    parameter int          STARVE_MAX = 4,
    parameter logic [31:0] RESET_ADDR = 32'h60000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    input  logic        flush,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic        busy
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    arb_state_t state_q, state_d;
    mem_req_t   req_q, req_d;
    logic       kill_q, kill_d;

    logic i_req, d_req, in_idle, limit_hit;
    logic grant_i, grant_d;

    assign i_req   = |imem_rmask;
    assign d_req   = |(dmem_rmask | dmem_wmask);
    assign in_idle = (state_q == IDLE);

    // A flush in IDLE blocks the I grant; D can still take the port that cycle.
    assign grant_i = in_idle & i_req & ~flush & (limit_hit | ~d_req);
    assign grant_d = in_idle & d_req & ~grant_i;

    arb_starve_counter #(.MAX(STARVE_MAX), .CW(CW)) u_starve (
        .clk       (clk),
        .rst       (rst),
        .inc       (grant_d & i_req),
        .clr       (grant_i | (in_idle & ~i_req)),
        .sat       (CW'(STARVE_MAX)),
        .limit_hit (limit_hit)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        kill_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    req_d   = '{addr: imem_addr, rmask: imem_rmask, wmask: 4'h0, wdata: 32'h0};
                    state_d = BUSY_I;
                end else if (grant_d) begin
                    req_d   = '{addr: dmem_addr, rmask: dmem_rmask, wmask: dmem_wmask, wdata: dmem_wdata};
                    state_d = BUSY_D;
                end else begin
                    req_d.rmask = 4'h0;
                    req_d.wmask = 4'h0;
                end
            end
            BUSY_I: begin
                // The killed fetch still runs to completion on memory; only its response is dropped.
                kill_d = (kill_q | flush) & ~mem_resp;
                if (mem_resp) begin
                    req_d.rmask = 4'h0;
                    req_d.wmask = 4'h0;
                    state_d     = IDLE;
                end
            end
            BUSY_D: begin
                if (mem_resp) begin
                    req_d.rmask = 4'h0;
                    req_d.wmask = 4'h0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= '{addr: RESET_ADDR, rmask: 4'h0, wmask: 4'h0, wdata: 32'h0};
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            kill_q  <= kill_d;
        end
    end

    assign mem_addr   = req_q.addr;
    assign mem_rmask  = req_q.rmask;
    assign mem_wmask  = req_q.wmask;
    assign mem_wdata  = req_q.wdata;
    assign busy       = ~in_idle;
    assign imem_resp  = mem_resp & (state_q == BUSY_I) & ~kill_q & ~flush;
    assign dmem_resp  = mem_resp & (state_q == BUSY_D);
    assign imem_rdata = mem_rdata;
    assign dmem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter: one row per clock cycle,
// inputs applied after the falling edge and outputs compared 1 ns later.
module tb_mem_port_arbiter;
    import rv32i_types::*;

    localparam logic [31:0] A0 = 32'h60000000;
    localparam logic [31:0] IA = 32'h60000010;
    localparam logic [31:0] DA = 32'h60001000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr = '0, dmem_addr = '0, dmem_wdata = '0, mem_rdata = '0;
    logic [3:0]  imem_rmask = '0, dmem_rmask = '0, dmem_wmask = '0;
    logic        flush = 1'b0, mem_resp = 1'b0;
    logic [31:0] imem_rdata, dmem_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_rmask, mem_wmask;
    logic        imem_resp, dmem_resp, busy;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .flush(flush),
        .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst, flush;
        logic [3:0]  irm;
        logic [31:0] ia;
        logic [3:0]  drm, dwm;
        logic [31:0] da, dwd;
        logic        mresp;
        logic [31:0] mrd;
        logic        e_busy;
        logic [3:0]  e_rm, e_wm;
        logic        e_chka;
        logic [31:0] e_addr, e_wdata;
        logic        e_ir, e_dr;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(string name, logic r, logic fl, logic [3:0] irm, logic [31:0] ia,
                                logic [3:0] drm, logic [3:0] dwm, logic [31:0] da, logic [31:0] dwd,
                                logic mresp, logic [31:0] mrd, logic e_busy, logic [3:0] e_rm,
                                logic [3:0] e_wm, logic e_chka, logic [31:0] e_addr,
                                logic [31:0] e_wdata, logic e_ir, logic e_dr);
        vec_t v;
        v.name = name; v.rst = r; v.flush = fl; v.irm = irm; v.ia = ia; v.drm = drm; v.dwm = dwm;
        v.da = da; v.dwd = dwd; v.mresp = mresp; v.mrd = mrd; v.e_busy = e_busy; v.e_rm = e_rm;
        v.e_wm = e_wm; v.e_chka = e_chka; v.e_addr = e_addr; v.e_wdata = e_wdata;
        v.e_ir = e_ir; v.e_dr = e_dr;
        tbl.push_back(v);
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    initial begin
        // Reset pulse placed before the first rising edge: outputs must settle with no clock.
        #3 rst = 1'b1;
        #1;
        chk("async_rst.busy", busy, 0);
        chk("async_rst.addr", mem_addr, A0);
        chk("async_rst.rmask", mem_rmask, 0);
        chk("async_rst.wmask", mem_wmask, 0);
        chk("async_rst.wdata", mem_wdata, 0);
        chk("async_rst.iresp", imem_resp, 0);
        chk("async_rst.dresp", dmem_resp, 0);

        //   name            rst fl irm   ia          drm   dwm   da          dwd   mr rdata         busy rm    wm    ca addr        wdata ir dr
        add("reset",         1, 0, 4'h0, 0,          4'h0, 4'h0, 0,          0,    0, 0,            0,   4'h0, 4'h0, 1, A0,         0,    0, 0);
        add("if_idle",       0, 0, 4'hF, A0,         4'h0, 4'h0, 0,          0,    0, 0,            0,   4'h0, 4'h0, 1, A0,         0,    0, 0);
        add("if_issue",      0, 0, 4'hF, A0,         4'h0, 4'h0, 0,          0,    0, 0,            1,   4'hF, 4'h0, 1, A0,         0,    0, 0);
        add("if_wait",       0, 0, 4'hF, A0,         4'h0, 4'h0, 0,          0,    0, 0,            1,   4'hF, 4'h0, 1, A0,         0,    0, 0);
        add("if_resp",       0, 0, 4'hF, A0,         4'h0, 4'h0, 0,          0,    1, 32'h00500093, 1,   4'hF, 4'h0, 1, A0,         0,    1, 0);
        add("if_done",       0, 0, 4'h0, 0,          4'h0, 4'h0, 0,          0,    0, 0,            0,   4'h0, 4'h0, 1, A0,         0,    0, 0);
        // Four D writes win while I waits; the fifth grant must go to I, then D wins again.
        for (int k = 1; k <= 6; k++) begin
            add($sformatf("cont%0d_idle", k), 0, 0, 4'hF, IA, 4'h0, 4'h3, DA, 32'hA5A50000 + k,
                0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 0);
            if (k == 5)
                add("cont5_igrant", 0, 0, 4'hF, IA, 4'h0, 4'h3, DA, 32'hA5A50005,
                    1, NOP_INST, 1, 4'hF, 4'h0, 1, IA, 0, 1, 0);
            else
                add($sformatf("cont%0d_dgrant", k), 0, 0, 4'hF, IA, 4'h0, 4'h3, DA, 32'hA5A50000 + k,
                    1, 32'hDEADBEEF, 1, 4'h0, 4'h3, 1, DA, 32'hA5A50000 + k, 0, 1);
        end
        add("cont_end",      0, 0, 4'h0, 0,          4'h0, 4'h0, 0,          0,    0, 0,            0,   4'h0, 4'h0, 0, 0,          0,    0, 0);
        add("fk_idle",       0, 0, 4'hF, 32'h60000020, 4'h0, 4'h0, 0,        0,    0, 0,            0,   4'h0, 4'h0, 0, 0,          0,    0, 0);
        add("fk_flush",      0, 1, 4'hF, 32'h60000020, 4'h0, 4'h0, 0,        0,    0, 0,            1,   4'hF, 4'h0, 1, 32'h60000020, 0,  0, 0);
        add("fk_killed",     0, 0, 4'hF, 32'h60000040, 4'h0, 4'h0, 0,        0,    1, 32'h00500093, 1,   4'hF, 4'h0, 1, 32'h60000020, 0,  0, 0);
        add("fk_reidle",     0, 0, 4'hF, 32'h60000040, 4'h0, 4'h0, 0,        0,    0, 0,            0,   4'h0, 4'h0, 0, 0,          0,    0, 0);
        add("fk_refetch",    0, 0, 4'hF, 32'h60000040, 4'h0, 4'h0, 0,        0,    1, 32'h00500093, 1,   4'hF, 4'h0, 1, 32'h60000040, 0,  1, 0);
        add("fk_end",        0, 0, 4'h0, 0,          4'h0, 4'h0, 0,          0,    0, 0,            0,   4'h0, 4'h0, 0, 0,          0,    0, 0);
        add("fi_idle",       0, 1, 4'hF, 32'h60000080, 4'hF, 4'h0, 32'h60002000, 0, 0, 0,           0,   4'h0, 4'h0, 0, 0,          0,    0, 0);
        add("fi_dgrant",     0, 0, 4'hF, 32'h60000080, 4'hF, 4'h0, 32'h60002000, 0, 0, 0,           1,   4'hF, 4'h0, 1, 32'h60002000, 0,  0, 0);
        add("fi_dresp_fl",   0, 1, 4'hF, 32'h60000080, 4'hF, 4'h0, 32'h60002000, 0, 1, 32'h12345678, 1,  4'hF, 4'h0, 1, 32'h60002000, 0,  0, 1);
        add("fi_iidle",      0, 0, 4'hF, 32'h60000080, 4'h0, 4'h0, 0,        0,    0, 0,            0,   4'h0, 4'h0, 0, 0,          0,    0, 0);
        add("fi_iresp",      0, 0, 4'hF, 32'h60000080, 4'h0, 4'h0, 0,        0,    1, NOP_INST,     1,   4'hF, 4'h0, 1, 32'h60000080, 0,  1, 0);
        add("fi_end",        0, 0, 4'h0, 0,          4'h0, 4'h0, 0,          0,    0, 0,            0,   4'h0, 4'h0, 0, 0,          0,    0, 0);
        add("fr_idle",       0, 0, 4'hF, 32'h60000090, 4'h0, 4'h0, 0,        0,    0, 0,            0,   4'h0, 4'h0, 0, 0,          0,    0, 0);
        add("fr_flush_resp", 0, 1, 4'hF, 32'h60000090, 4'h0, 4'h0, 0,        0,    1, NOP_INST,     1,   4'hF, 4'h0, 1, 32'h60000090, 0,  0, 0);
        add("fr_idle2",      0, 0, 4'hF, 32'h600000A0, 4'h0, 4'h0, 0,        0,    0, 0,            0,   4'h0, 4'h0, 0, 0,          0,    0, 0);
        add("fr_resp2",      0, 0, 4'hF, 32'h600000A0, 4'h0, 4'h0, 0,        0,    1, NOP_INST,     1,   4'hF, 4'h0, 1, 32'h600000A0, 0,  1, 0);
        add("rw_idle",       0, 0, 4'h0, 0,          4'h3, 4'hC, 32'h60004000, 32'hCAFEF00D, 0, 0,  0,   4'h0, 4'h0, 0, 0,          0,    0, 0);
        add("rw_resp",       0, 0, 4'h0, 0,          4'h3, 4'hC, 32'h60004000, 32'hCAFEF00D, 1, 32'h0BADF00D, 1, 4'h3, 4'hC, 1, 32'h60004000, 32'hCAFEF00D, 0, 1);
        add("rm_idle",       0, 0, 4'h0, 0,          4'hF, 4'h0, 32'h60003000, 0, 0, 0,             0,   4'h0, 4'h0, 0, 0,          0,    0, 0);
        add("rm_rst",        1, 0, 4'h0, 0,          4'hF, 4'h0, 32'h60003000, 0, 0, 0,             0,   4'h0, 4'h0, 1, A0,         0,    0, 0);
        add("rm_late_resp",  0, 0, 4'h0, 0,          4'h0, 4'h0, 0,          0,    1, 32'hDEADBEEF, 0,   4'h0, 4'h0, 1, A0,         0,    0, 0);
        add("rm_after",      0, 0, 4'h0, 0,          4'h0, 4'h0, 0,          0,    0, 0,            0,   4'h0, 4'h0, 1, A0,         0,    0, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst; flush = tbl[i].flush;
            imem_rmask = tbl[i].irm; imem_addr = tbl[i].ia;
            dmem_rmask = tbl[i].drm; dmem_wmask = tbl[i].dwm;
            dmem_addr = tbl[i].da; dmem_wdata = tbl[i].dwd;
            mem_resp = tbl[i].mresp; mem_rdata = tbl[i].mrd;
            #1;
            chk({tbl[i].name, ".busy"},  busy,      tbl[i].e_busy);
            chk({tbl[i].name, ".rmask"}, mem_rmask, tbl[i].e_rm);
            chk({tbl[i].name, ".wmask"}, mem_wmask, tbl[i].e_wm);
            chk({tbl[i].name, ".iresp"}, imem_resp, tbl[i].e_ir);
            chk({tbl[i].name, ".dresp"}, dmem_resp, tbl[i].e_dr);
            if (tbl[i].e_chka) begin
                chk({tbl[i].name, ".addr"},  mem_addr,  tbl[i].e_addr);
                chk({tbl[i].name, ".wdata"}, mem_wdata, tbl[i].e_wdata);
            end
            if (tbl[i].e_ir) chk({tbl[i].name, ".irdata"}, imem_rdata, tbl[i].mrd);
            if (tbl[i].e_dr) chk({tbl[i].name, ".drdata"}, dmem_rdata, tbl[i].mrd);
        end

        // Reset asserted between edges while a fetch is outstanding.
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; mem_resp = 1'b0;
        dmem_rmask = 4'h0; dmem_wmask = 4'h0;
        imem_rmask = 4'hF; imem_addr = 32'h600000B0;
        begin
            int n = 0;
            while (!busy && n < 8) begin
                @(posedge clk); #1; n++;
            end
            chk("midrst.granted", busy, 1);
        end
        chk("midrst.addr_before", mem_addr, 32'h600000B0);
        #2 rst = 1'b1;
        #1;
        chk("midrst.busy", busy, 0);
        chk("midrst.rmask", mem_rmask, 0);
        chk("midrst.addr", mem_addr, A0);
        mem_resp = 1'b1;
        #0.5;
        chk("midrst.iresp", imem_resp, 0);
        @(negedge clk);
        rst = 1'b0; imem_rmask = 4'h0; mem_resp = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the fetch stage (I-side) and the memory stage (D-side).
- Accepts one request at a time from either side and registers the address, masks and write data at grant.
- Holds the shared port stable until the memory responds, then routes the response back to the owner.
- Drops a fetch response that a pipeline flush has made stale, and bounds how long the I-side can be starved.

Parameters:
- STARVE_MAX, 4: consecutive D-side grants allowed while an I-side request waits; the next grant then goes to the I-side.
- RESET_ADDR, 32'h60000000: reset value of the registered mem_addr.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- imem_addr  in  32  fetch address.
- imem_rmask  in  4  fetch read mask; nonzero means an I-side request.
- imem_rdata  out  32  fetch data.
- imem_resp  out  1  fetch response.
- dmem_addr  in  32  data address.
- dmem_rmask  in  4  data read mask.
- dmem_wmask  in  4  data write mask.
- dmem_wdata  in  32  data write data.
- dmem_rdata  out  32  data read data.
- dmem_resp  out  1  data response.
- flush  in  1  pipeline flush; kills the in-flight or pending I-side request.
- mem_addr  out  32  shared port address.
- mem_rmask  out  4  shared port read mask.
- mem_wmask  out  4  shared port write mask.
- mem_wdata  out  32  shared port write data.
- mem_rdata  in  32  shared port read data.
- mem_resp  in  1  shared port response.
- busy  out  1  high while a request is outstanding.

Behaviour:
- Reset: asynchronous, active-high. On assertion:
  - state=IDLE, owner=NONE, kill=0, starve_cnt=0.
  - mem_addr=RESET_ADDR; mem_rmask, mem_wmask, mem_wdata = 0.
  - imem_resp, dmem_resp, busy = 0.
  - Reset during BUSY abandons the transaction; a later mem_resp with owner=NONE is ignored.
- Request definition:
  - I-side request: imem_rmask != 0.
  - D-side request: (dmem_rmask | dmem_wmask) != 0.
  - Requesters hold the request until their resp.
- States:
  - IDLE: if any request is present, a grant is decided combinationally and registered at the clock edge. The granted address, masks and wdata are latched into the mem_* registers. Next state: BUSY_I or BUSY_D. If no request, stay in IDLE with mem masks = 0.
  - BUSY_I / BUSY_D: mem_* held constant. On mem_resp, masks clear at the next edge and the state returns to IDLE.
- Priority:
  - D-side wins whenever starve_cnt < STARVE_MAX; otherwise the I-side wins.
  - starve_cnt increments on each D grant made while an I request was pending.
  - starve_cnt clears on any I grant, or when an IDLE cycle has no I request. It saturates at STARVE_MAX.
- Response routing:
  - Combinational in the mem_resp cycle, zero added latency.
  - imem_resp = mem_resp & BUSY_I & ~kill & ~flush.
  - dmem_resp = mem_resp & BUSY_D.
  - imem_rdata = mem_rdata; dmem_rdata = mem_rdata. Data is qualified only by resp.
- Latency: request seen in IDLE -> mem request visible on the next cycle. Back-to-back requests are separated by one IDLE cycle.
- Flush:
  - flush in BUSY_I sets kill. The transaction completes on memory, but imem_resp is suppressed. kill clears on leaving BUSY_I.
  - flush in IDLE blocks an I grant that cycle; a D grant is unaffected.
  - flush in BUSY_D has no effect.
- Writes: a D write completes with dmem_resp; dmem_rdata is don't-care. Simultaneous rmask and wmask from the D-side are issued as given.
- busy = (state != IDLE).

Decomposition:
- Shared package rv32i_types gains:
  - arb_state_t enum {IDLE, BUSY_I, BUSY_D}.
  - mem_req_t struct {addr, rmask, wmask, wdata}.
  - constant NOP_INST = 32'h00000013 for benches.
- The starvation counter is a natural sub-module, arb_starve_counter: inputs inc, clr, sat; output limit_hit.
- The FSM and datapath registers stay in the top module.

Test Plan:
- Reset:
  - Stimulus: rst pulse asynchronous to clk.
  - Required: all outputs at reset values immediately, before the next clk edge; mem_addr=32'h60000000.
- I-only fetch:
  - Stimulus: imem_addr=32'h60000000, rmask=4'hF; memory responds 2 cycles after issue with rdata=32'h00500093.
  - Required: mem_rmask=4'hF the cycle after the request; imem_resp=1 with rdata=32'h00500093 in the mem_resp cycle; back in IDLE next cycle.
- Contention:
  - Stimulus: I and D requests both held; dmem_addr=32'h60001000 with wmask=4'h3.
  - Required: D granted first, then another D for each new D request up to 4 consecutive; 5th grant goes to I; starve_cnt=0 after it.
- Flush kill:
  - Stimulus: I grant issued, then flush in BUSY_I before mem_resp.
  - Required: mem_resp arrives but imem_resp stays 0; the next I grant uses the new imem_addr=32'h60000040.
- Flush in IDLE with D pending:
  - Stimulus: flush, I and D requests all present in IDLE.
  - Required: D granted; no I grant issued that cycle.
- Reset mid-transaction:
  - Stimulus: rst asserted in BUSY_D, then mem_resp arrives after release.
  - Required: dmem_resp=0; state IDLE; no spurious resp.
